// File: rtl/nibble_serial_adder_if.sv
// Request/result bundle for the nibble-serial adder.
// The ovf signal exists only when NSA_OVERFLOW_EN is defined.
interface nibble_serial_adder_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef NSA_OVERFLOW_EN
    logic         ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );
`else
    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
`endif
endinterface

// File: rtl/nibble_serial_adder.sv
// Wide adder sequencing one 4-bit CLA slice over NIBBLES cycles, LSB nibble first.
// Optional signed-overflow flag enabled by defining NSA_OVERFLOW_EN.
module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [3:0] p;
    logic [3:0] g;
    logic [3:1] c;

    assign p = a ^ b;
    assign g = a & b;

    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & ci);
    assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s = p ^ {c[3], c[2], c[1], ci};
endmodule

module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input logic                 clk,
    input logic                 rst,
    nibble_serial_adder_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  sum_q;
    logic          carry;
    logic          cout_q;
    logic [3:0]    a_nib;
    logic [3:0]    b_nib;
    logic [3:0]    s;
    logic          c;
    logic          accept;
    logic          last;
`ifdef NSA_OVERFLOW_EN
    logic          ovf_q;
`endif

    // A request is taken in IDLE and also in DONE for back-to-back use.
    assign accept = bus.start && (state != RUN);
    assign last   = (cnt == CW'(NIBBLES - 1));

    assign a_nib = a_reg[4*int'(cnt) +: 4];
    assign b_nib = b_reg[4*int'(cnt) +: 4];

    cla_4bit u_slice (
        .a  (a_nib),
        .b  (b_nib),
        .ci (carry),
        .s  (s),
        .co (c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
`ifdef NSA_OVERFLOW_EN
            ovf_q  <= 1'b0;
`endif
        end else if (accept) begin
            state <= RUN;
            cnt   <= '0;
            a_reg <= bus.a;
            b_reg <= bus.b;
            carry <= bus.cin;
            sum_q <= '0;
`ifdef NSA_OVERFLOW_EN
            ovf_q <= 1'b0;
`endif
        end else begin
            case (state)
                RUN: begin
                    sum_q[4*int'(cnt) +: 4] <= s;
                    carry <= c;
                    if (last) begin
                        state  <= DONE;
                        cout_q <= c;
`ifdef NSA_OVERFLOW_EN
                        ovf_q  <= (a_reg[W-1] == b_reg[W-1])
                               && (s[3] != a_reg[W-1]);
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
`ifdef NSA_OVERFLOW_EN
    assign bus.ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: directed cases plus random traffic.
// A separate monitor compares every done pulse against queued model results.
module tb_nibble_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   pass_cnt = 0;
    int   tot_cnt = 0;
    bit   mon_en = 1'b0;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          due;
    } exp_t;

    exp_t sb[$];

    nibble_serial_adder_if #(.NIBBLES(4)) ifc ();
    nibble_serial_adder_if #(.NIBBLES(1)) ifc1 ();

    nibble_serial_adder #(.NIBBLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    nibble_serial_adder #(.NIBBLES(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (ifc1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        tot_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                      name, got, exp, cyc);
    endtask

    // Reference: plain integer arithmetic; overflow from signed range.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input int due);
        exp_t e;
        logic [16:0] full;
        int sv;
        full = 17'(a) + 17'(b) + 17'(cin);
        sv = int'($signed(a)) + int'($signed(b)) + int'(cin);
        e.sum  = full[15:0];
        e.cout = full[16];
        e.ovf  = (sv > 32767) || (sv < -32768);
        e.due  = due;
        return e;
    endfunction

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (ifc.done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(ifc.done), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_latency", cyc, e.due);
                    chk("sum", 32'(ifc.sum), 32'(e.sum));
                    chk("cout", 32'(ifc.cout), 32'(e.cout));
`ifdef NSA_OVERFLOW_EN
                    chk("ovf", 32'(ifc.ovf), 32'(e.ovf));
`endif
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                chk("done_missing", 32'(ifc.done), 32'd1);
                void'(sb.pop_front());
            end
        end
    end

    // Called at a negedge where the DUT is IDLE or DONE; returns at the
    // DONE negedge of this request. junk=1 holds start high with a=FFFF.
    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input int junk);
        ifc.start = 1'b1;
        ifc.a = a;
        ifc.b = b;
        ifc.cin = cin;
        sb.push_back(model(a, b, cin, cyc + 5));
        @(negedge clk);
        chk("sum_cleared", 32'(ifc.sum), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("busy_run", 32'(ifc.busy), 32'd1);
            if (junk == 1) begin
                ifc.start = 1'b1;
                ifc.a = 16'hFFFF;
            end else begin
                ifc.start = 1'($urandom_range(0, 1));
                ifc.a = 16'($urandom);
            end
            ifc.b = 16'($urandom);
            ifc.cin = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        chk("busy_done", 32'(ifc.busy), 32'd0);
        ifc.start = 1'b0;
    endtask

    initial begin
        ifc1.start = 1'b0;
        ifc1.a = '0;
        ifc1.b = '0;
        ifc1.cin = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        ifc1.start = 1'b1;
        ifc1.a = 4'd8;
        ifc1.b = 4'd7;
        ifc1.cin = 1'b1;
        @(negedge clk);
        ifc1.start = 1'b0;
        chk("n1_busy", 32'(ifc1.busy), 32'd1);
        chk("n1_early_done", 32'(ifc1.done), 32'd0);
        @(negedge clk);
        chk("n1_done", 32'(ifc1.done), 32'd1);
        chk("n1_sum", 32'(ifc1.sum), 32'd0);
        chk("n1_cout", 32'(ifc1.cout), 32'd1);
        @(negedge clk);
        chk("n1_done_pulse", 32'(ifc1.done), 32'd0);
    end

    initial begin
        ifc.start = 1'b0;
        ifc.a = '0;
        ifc.b = '0;
        ifc.cin = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(ifc.busy), 32'd0);
        chk("rst_done", 32'(ifc.done), 32'd0);
        chk("rst_sum", 32'(ifc.sum), 32'd0);
        chk("rst_cout", 32'(ifc.cout), 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        issue(16'hFFFF, 16'h0000, 1'b1, 0);
        @(negedge clk);
        issue(16'h1234, 16'h4321, 1'b0, 0);
        @(negedge clk);
        issue(16'h00FF, 16'h0001, 1'b0, 1);
        issue(16'h7FFF, 16'h0001, 1'b0, 0);
        issue(16'hFFFF, 16'h0001, 1'b0, 0);
        @(negedge clk);

        // Abort in the second RUN cycle; no result is queued.
        ifc.start = 1'b1;
        ifc.a = 16'hAAAA;
        ifc.b = 16'h5555;
        ifc.cin = 1'b0;
        @(negedge clk);
        ifc.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(ifc.busy), 32'd0);
        chk("abort_done", 32'(ifc.done), 32'd0);
        chk("abort_sum", 32'(ifc.sum), 32'd0);
        chk("abort_cout", 32'(ifc.cout), 32'd0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", 32'(ifc.done), 32'd0);
        end
        issue(16'hAAAA, 16'h5555, 1'b0, 0);

        for (int n = 0; n < 40; n++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            repeat (gap) @(negedge clk);
            issue(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 0);
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
